// File: rtl/noc_pkt_store_fwd.sv
// noc_pkt_store_fwd: packet-level store-and-forward flit FIFO.
// A packet is made visible on the output side only once every one of its
// flits has been written. Headers carry the payload length in bits [29:22];
// packets too large to ever fit are swallowed and flagged.
// Optional forwarded-packet counter: define NOC_PKT_STORE_FWD_STATS_EN.
module noc_pkt_store_fwd #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_val,
   input  logic [DATA_WIDTH-1:0]   in_dat,
   output logic                    in_rdy,
   output logic                    out_val,
   output logic [DATA_WIDTH-1:0]   out_dat,
   input  logic                    out_rdy,
   output logic [$clog2(DEPTH):0]  pkts_stored_o,
   output logic                    err_oversize_o,
   output logic [31:0]             stat_pkts_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IN_HDR, IN_BODY, IN_DROP} inState_t;
   typedef enum logic {OUT_HDR, OUT_BODY} outState_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wrPtr;
   logic [AW:0]           r_rdPtr;
   logic [AW:0]           r_pktsStored;
   logic [7:0]            r_inRem;
   logic [7:0]            r_outRem;
   logic                  r_errOversize;
   inState_t              r_inState;
   outState_t             r_outState;

   logic                  w_full;
   logic                  w_inAcc;
   logic                  w_pop;
   logic [7:0]            w_inLen;
   logic [7:0]            w_outLen;
   logic                  w_fits;
   logic                  w_wrEn;
   logic                  w_commit;
   logic                  w_errSet;
   logic                  w_lastPop;
   logic [7:0]            w_inRemNext;
   logic [7:0]            w_outRemNext;
   inState_t              w_inStateNext;
   outState_t             w_outStateNext;

   assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_inLen  = in_dat[29:22];
   assign w_outLen = out_dat[29:22];
   assign w_fits   = (32'(w_inLen) + 32'd1) <= 32'(DEPTH);

   assign pkts_stored_o  = r_pktsStored;
   assign err_oversize_o = r_errOversize;

   // Input side: decide accept/write/commit/drop for the incoming flit
   always_comb begin
      w_inStateNext = r_inState;
      w_inRemNext   = r_inRem;
      w_wrEn        = 1'b0;
      w_commit      = 1'b0;
      w_errSet      = 1'b0;
      in_rdy        = !reset && ((r_inState == IN_DROP) || !w_full);
      w_inAcc       = in_val && in_rdy;
      case (r_inState)
         IN_HDR: begin
            if (w_inAcc) begin
               if (w_inLen == 8'd0) begin
                  w_wrEn   = 1'b1;
                  w_commit = 1'b1;
               end else if (w_fits) begin
                  w_wrEn        = 1'b1;
                  w_inRemNext   = w_inLen;
                  w_inStateNext = IN_BODY;
               end else begin
                  w_errSet      = 1'b1;
                  w_inRemNext   = w_inLen;
                  w_inStateNext = IN_DROP;
               end
            end
         end
         IN_BODY: begin
            if (w_inAcc) begin
               w_wrEn      = 1'b1;
               w_inRemNext = r_inRem - 8'd1;
               if (r_inRem == 8'd1) begin
                  w_commit      = 1'b1;
                  w_inStateNext = IN_HDR;
               end
            end
         end
         IN_DROP: begin
            if (w_inAcc) begin
               w_inRemNext = r_inRem - 8'd1;
               if (r_inRem == 8'd1) begin
                  w_inStateNext = IN_HDR;
               end
            end
         end
         default: w_inStateNext = IN_HDR;
      endcase
   end

   // Output side: present the head flit and track where the head packet ends
   always_comb begin
      w_outStateNext = r_outState;
      w_outRemNext   = r_outRem;
      w_lastPop      = 1'b0;
      out_val        = !reset && (r_pktsStored != '0);
      out_dat        = r_mem[r_rdPtr[AW-1:0]];
      w_pop          = out_val && out_rdy;
      case (r_outState)
         OUT_HDR: begin
            if (w_pop) begin
               if (w_outLen == 8'd0) begin
                  w_lastPop = 1'b1;
               end else begin
                  w_outRemNext   = w_outLen;
                  w_outStateNext = OUT_BODY;
               end
            end
         end
         OUT_BODY: begin
            if (w_pop) begin
               w_outRemNext = r_outRem - 8'd1;
               if (r_outRem == 8'd1) begin
                  w_lastPop      = 1'b1;
                  w_outStateNext = OUT_HDR;
               end
            end
         end
         default: w_outStateNext = OUT_HDR;
      endcase
   end

   // State registers for both FSMs and their remaining-flit counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inState  <= IN_HDR;
         r_outState <= OUT_HDR;
         r_inRem    <= 8'd0;
         r_outRem   <= 8'd0;
      end else begin
         r_inState  <= w_inStateNext;
         r_outState <= w_outStateNext;
         r_inRem    <= w_inRemNext;
         r_outRem   <= w_outRemNext;
      end
   end

   // Flit storage; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[r_wrPtr[AW-1:0]] <= in_dat;
      end
   end

   // Pointers, committed-packet count and the sticky oversize flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_pktsStored  <= '0;
         r_errOversize <= 1'b0;
      end else begin
         if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
         end
         case ({w_commit, w_lastPop})
            2'b10:   r_pktsStored <= r_pktsStored + {{AW{1'b0}}, 1'b1};
            2'b01:   r_pktsStored <= r_pktsStored - {{AW{1'b0}}, 1'b1};
            default: r_pktsStored <= r_pktsStored;
         endcase
         if (w_errSet) begin
            r_errOversize <= 1'b1;
         end
      end
   end

`ifdef NOC_PKT_STORE_FWD_STATS_EN
   logic [31:0] r_statPkts;

   // Saturating count of packets fully forwarded to the bridge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_statPkts <= 32'd0;
      end else if (w_lastPop && (r_statPkts != 32'hFFFF_FFFF)) begin
         r_statPkts <= r_statPkts + 32'd1;
      end
   end

   assign stat_pkts_o = r_statPkts;
`else
   assign stat_pkts_o = 32'd0;
`endif

endmodule

// File: tb/tb_noc_pkt_store_fwd.sv
// tb_noc_pkt_store_fwd: directed and randomized bench with a packet-level
// queue model of the store-and-forward FIFO.
module tb_noc_pkt_store_fwd;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_val;
   logic [DW-1:0] in_dat;
   logic          in_rdy;
   logic          out_val;
   logic [DW-1:0] out_dat;
   logic          out_rdy;
   logic [AW:0]   pkts_stored_o;
   logic          err_oversize_o;
   logic [31:0]   stat_pkts_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: stored flits in order, lengths of committed packets
   logic [63:0] mMem[$];
   int          mPktLen[$];
   int          mHeadPopped;
   int          mCurLen;
   int          mRem;
   bit          mInPkt;
   bit          mDrop;
   bit          mErr;
   logic [31:0] mStat;

   noc_pkt_store_fwd #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_val         (in_val),
      .in_dat         (in_dat),
      .in_rdy         (in_rdy),
      .out_val        (out_val),
      .out_dat        (out_dat),
      .out_rdy        (out_rdy),
      .pkts_stored_o  (pkts_stored_o),
      .err_oversize_o (err_oversize_o),
      .stat_pkts_o    (stat_pkts_o)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mMem.delete();
      mPktLen.delete();
      mHeadPopped = 0;
      mCurLen     = 0;
      mRem        = 0;
      mInPkt      = 1'b0;
      mDrop       = 1'b0;
      mErr        = 1'b0;
      mStat       = 32'd0;
   endtask

   task automatic modelPush(input logic [63:0] d);
      int len;
      len = int'(d[29:22]);
      if (!mInPkt) begin
         if (len == 0) begin
            mMem.push_back(d);
            mPktLen.push_back(1);
         end else if (1 + len <= DEPTH) begin
            mMem.push_back(d);
            mCurLen = 1 + len;
            mRem    = len;
            mInPkt  = 1'b1;
            mDrop   = 1'b0;
         end else begin
            mErr   = 1'b1;
            mRem   = len;
            mInPkt = 1'b1;
            mDrop  = 1'b1;
         end
      end else begin
         if (!mDrop) mMem.push_back(d);
         mRem--;
         if (mRem == 0) begin
            if (!mDrop) mPktLen.push_back(mCurLen);
            mInPkt = 1'b0;
            mDrop  = 1'b0;
         end
      end
   endtask

   task automatic modelPop();
      void'(mMem.pop_front());
      mHeadPopped++;
      if (mHeadPopped == mPktLen[0]) begin
         void'(mPktLen.pop_front());
         mHeadPopped = 0;
         if (mStat != 32'hFFFF_FFFF) mStat = mStat + 32'd1;
      end
   endtask

   function automatic logic [31:0] expStat();
`ifdef NOC_PKT_STORE_FWD_STATS_EN
      return mStat;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [63:0] mkHdr(input int len);
      logic [63:0] d;
      d = {$urandom, $urandom};
      d[29:22] = 8'(len);
      return d;
   endfunction

   // One clock cycle: drive, check all outputs against the model, advance model
   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy, output bit accepted);
      bit eRdy;
      bit eVal;
      bit pop;
      in_val  = v;
      in_dat  = d;
      out_rdy = ordy;
      @(negedge clk);
      eRdy = mDrop || (mMem.size() < DEPTH);
      eVal = (mPktLen.size() != 0);
      checkOutput("in_rdy", 64'(in_rdy), 64'(eRdy));
      checkOutput("out_val", 64'(out_val), 64'(eVal));
      if (eVal) checkOutput("out_dat", out_dat, mMem[0]);
      checkOutput("pkts_stored", 64'(pkts_stored_o), 64'(mPktLen.size()));
      checkOutput("err_oversize", 64'(err_oversize_o), 64'(mErr));
      checkOutput("stat_pkts", 64'(stat_pkts_o), 64'(expStat()));
      accepted = v && eRdy;
      pop      = eVal && ordy;
      @(posedge clk);
      if (pop) modelPop();
      if (accepted) modelPush(d);
      #1;
   endtask

   task automatic sendFlit(input logic [63:0] d, input logic ordy);
      bit acc;
      int tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
         applyStimulus(1'b1, d, ordy, acc);
         tries++;
      end
      checkOutput("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic sendPkt(input int len, input logic ordy);
      sendFlit(mkHdr(len), ordy);
      for (int i = 0; i < len; i++) sendFlit({$urandom, $urandom}, ordy);
   endtask

   task automatic idle(input int n, input logic ordy);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'd0, ordy, acc);
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (mPktLen.size() != 0 && n < 200) begin
         applyStimulus(1'b0, 64'd0, 1'b1, acc);
         n++;
      end
      @(negedge clk);
      checkOutput("drain_pkts", 64'(pkts_stored_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      reset   = 1'b1;
      in_val  = 1'b0;
      in_dat  = '0;
      out_rdy = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
         checkOutput("rst_out_val", 64'(out_val), 64'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   // Directed scenarios, then randomized traffic, then mid-packet reset
   initial begin
      bit          acc;
      int          txLeft;
      int          len;
      int          r;
      logic [63:0] txData;
      logic [63:0] hold;

      modelReset();
      doReset(2);

      // Back-to-back len=3 packet with the bridge always ready
      sendPkt(3, 1'b1);
      idle(4, 1'b1);
      drain();

      // Incomplete packet stays invisible during an input stall
      sendFlit(mkHdr(2), 1'b1);
      sendFlit({$urandom, $urandom}, 1'b1);
      idle(10, 1'b1);
      sendFlit({$urandom, $urandom}, 1'b1);
      drain();

      // Oversize header is swallowed along with its 20 body flits
      sendFlit(mkHdr(20), 1'b1);
      for (int i = 0; i < 20; i++) sendFlit({$urandom, $urandom}, 1'b1);
      idle(2, 1'b1);
      checkOutput("oversize_err", 64'(err_oversize_o), 64'd1);
      checkOutput("oversize_pkts", 64'(pkts_stored_o), 64'd0);

      // Fill with four len=3 packets, then a single pop cycle
      for (int p = 0; p < 4; p++) sendPkt(3, 1'b0);
      hold = mkHdr(0);
      applyStimulus(1'b1, hold, 1'b0, acc);
      checkOutput("full_pkts", 64'(pkts_stored_o), 64'd4);
      applyStimulus(1'b1, hold, 1'b1, acc);
      applyStimulus(1'b1, hold, 1'b0, acc);
      checkOutput("refill_acc", 64'(acc), 64'd1);
      drain();

      // Randomized packet traffic with random valid and ready
      txLeft = 0;
      txData = '0;
      for (int i = 0; i < 3000; i++) begin
         if (txLeft == 0) begin
            r = $urandom_range(0, 19);
            if (r < 14)      len = $urandom_range(0, 5);
            else if (r < 16) len = 15;
            else if (r < 18) len = 16;
            else             len = $urandom_range(0, 40);
            txData = mkHdr(len);
            txLeft = len + 1;
         end
         applyStimulus($urandom_range(0, 3) != 0, txData, $urandom_range(0, 3) != 0, acc);
         if (acc) begin
            txLeft--;
            if (txLeft > 0) txData = {$urandom, $urandom};
         end
      end

      // Reset after 2 of 5 flits, then a fresh packet must come through intact
      doReset(2);
      sendFlit(mkHdr(4), 1'b1);
      sendFlit({$urandom, $urandom}, 1'b1);
      doReset(2);
      idle(3, 1'b1);
      sendPkt(2, 1'b1);
      drain();
`ifdef NOC_PKT_STORE_FWD_STATS_EN
      checkOutput("final_stat", 64'(stat_pkts_o), 64'd1);
`else
      checkOutput("final_stat", 64'(stat_pkts_o), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_pkt_store_fwd.md
NOC_PKT_STORE_FWD -- requirements
Module: noc_pkt_store_fwd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, NoC flit width.
REQ-002 SHALL have parameter DEPTH, default 16, flit storage entries, power of two, minimum 4.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_val  input  1  upstream flit valid, from the credit-to-valrdy converter.
REQ-006 SHALL have port in_dat  input  DATA_WIDTH  upstream flit.
REQ-007 SHALL have port in_rdy  output  1  flit accepted when in_val and in_rdy are both high.
REQ-008 SHALL have port out_val  output  1  flit valid toward the NoC-to-AXI4 bridge.
REQ-009 SHALL have port out_dat  output  DATA_WIDTH  flit toward the bridge.
REQ-010 SHALL have port out_rdy  input  1  bridge ready; transfer occurs when out_val and out_rdy are both high.
REQ-011 SHALL have port pkts_stored_o  output  clog2(DEPTH)+1  complete packets held.
REQ-012 SHALL have port err_oversize_o  output  1  sticky oversize-drop flag.
REQ-013 SHALL have port stat_pkts_o  output  32  forwarded-packet count (see Configuration).

Function
REQ-014 SHALL be a store-and-forward FIFO: no flit of a packet is offered on out_* until all of that packet's flits have been written.
REQ-015 SHALL take packet length from header flit bits [29:22] (payload flits; packet = 1 + len flits; len 0 = header-only).
REQ-016 SHALL run an input FSM: IN_HDR (initial), IN_BODY, IN_DROP.
- IN_HDR, header accepted, len 0: commit, stay IN_HDR.
- IN_HDR, header accepted, 1+len <= DEPTH: write, load remaining = len, go to IN_BODY.
- IN_HDR, header accepted, 1+len > DEPTH: do not write, set err_oversize_o, load remaining = len, go to IN_DROP.
- IN_BODY: each accepted flit is written and decrements remaining; the flit that brings remaining to 0 commits and returns the FSM to IN_HDR.
- IN_DROP: each accepted flit is discarded and decrements remaining; at 0 the FSM returns to IN_HDR.
REQ-017 SHALL drive in_rdy = !full in IN_HDR and IN_BODY, and in_rdy = 1 in IN_DROP; no full-bypass: when full, in_rdy = 0 even if a pop occurs in the same cycle.
REQ-018 SHALL run an output FSM: OUT_HDR (initial) and OUT_BODY, tracking the remaining flits of the head packet from its header length; popping the last flit (header with len 0, or the final body flit) returns it to OUT_HDR.
REQ-019 SHALL drive out_val = (pkts_stored_o != 0); out_dat = storage[rd_ptr], combinational first-word-fall-through.
REQ-020 SHALL increment pkts_stored_o on commit and decrement it on last-flit pop; simultaneous commit and last-flit pop leave it unchanged.
REQ-021 SHALL give minimum latency of 1 cycle: last flit accepted in cycle N -> header valid on out_* in cycle N+1.
REQ-022 SHALL sustain 1 flit/cycle in and out simultaneously when neither full nor empty.
REQ-023 SHALL wrap pointers modulo DEPTH, with an extra MSB for full/empty discrimination.
REQ-024 SHALL hold out_dat stable while out_val=1 and out_rdy=0.

Reset
REQ-025 SHALL, on reset, clear pointers, pkts_stored_o, remaining counters, err_oversize_o and stat_pkts_o, and set the FSMs to IN_HDR/OUT_HDR.
REQ-026 SHALL drive out_val=0 and in_rdy=0 while reset is high, and in_rdy=1 in the first cycle after reset is released.
REQ-027 SHALL discard partially written packets on reset mid-packet; no flits are emitted after reset until a new complete packet arrives.

Configuration
REQ-028 SHALL use macro NOC_PKT_STORE_FWD_STATS_EN: when defined, stat_pkts_o increments by 1 on each last-flit pop and saturates at 0xFFFFFFFF; when undefined, stat_pkts_o is tied to 0 and no counter is built.

Verification
REQ-029 SHALL cover: packet len=3 sent back-to-back, out_rdy=1 -> out_val rises the cycle after the 4th flit is accepted; 4 flits out in 4 consecutive cycles.
REQ-030 SHALL cover: send header len=2 plus 1 body flit, then stall in_val 10 cycles -> out_val stays 0 for all 10 cycles.
REQ-031 SHALL cover: DEPTH=16, header len=20 -> in_rdy stays 1 for 21 flits, err_oversize_o=1, nothing emitted, pkts_stored_o=0.
REQ-032 SHALL cover: fill with four len=3 packets, out_rdy=0 -> in_rdy=0, pkts_stored_o=4; out_rdy=1 for 1 cycle -> in_rdy returns to 1 the next cycle.
REQ-033 SHALL cover: assert reset after 2 of 5 flits -> the next complete packet is emitted intact, stat_pkts_o=1 (STATS_EN defined) or 0 (undefined).
